// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared widths, opcodes, I/O addresses and FSM type for memory_stage
//
// Purpose: single home for the global definitions used by the memory stage
// and its data memory: register/opcode widths, load/store opcodes, the
// memory-mapped board I/O addresses and the wait-FSM state type.
// Ports: none (package).
package memory_stage_pkg;

   localparam int REG_WIDTH    = 16;
   localparam int OPCODE_WIDTH = 5;

   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 5'h01;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 5'h10;
   localparam logic [OPCODE_WIDTH-1:0] OP_STW = 5'h11;

   localparam logic [REG_WIDTH-1:0] ADDR_LEDR = 16'hFFF0;
   localparam logic [REG_WIDTH-1:0] ADDR_LEDG = 16'hFFF1;
   localparam logic [REG_WIDTH-1:0] ADDR_HEX  = 16'hFFF2;
   localparam logic [REG_WIDTH-1:0] ADDR_SW   = 16'hFFF3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
      return (op == OP_LDW) || (op == OP_STW);
   endfunction

endpackage

// File: rtl/memory_stage_data_mem.sv
// rtl/memory_stage_data_mem.sv - single-port data RAM, negedge write, read-before-write
//
// Purpose: word-addressed data memory for the memory stage. Array contents
// are never reset; only the registered read port is cleared by rst.
// Ports:
//   clk    in   clock, all updates on the falling edge
//   rst    in   asynchronous active-high reset of the read register
//   we     in   write enable
//   re     in   read enable; rdata only changes when re is set
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data (old contents on a same-address write)
module memory_stage_data_mem
   import memory_stage_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic                 re,
   input  logic [AW-1:0]        addr,
   input  logic [REG_WIDTH-1:0] wdata,
   output logic [REG_WIDTH-1:0] rdata
);

   logic [REG_WIDTH-1:0] mem [0:(1<<AW)-1];

   always_ff @(negedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Sampled on the same edge as the write, so the read sees the old word.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline memory stage with wait-state FSM and optional board I/O
//
// Purpose: consumes the Execute bundle, performs LDW/STW against the data
// memory (with DMEM_LATENCY extra wait cycles) and forwards results and
// stall flags to Writeback. O_MemStall holds the upstream stages while a
// delayed access is pending.
// Build option: define MEM_IO_EN to map LEDR/LEDG/HEX/SW into the address
// space; without it those addresses are ordinary memory and the LED/HEX
// ports are tied to 0.
// Ports:
//   I_CLOCK, I_RESET                  clock (negedge) and async active-high reset
//   I_LOCK                            upstream valid
//   I_Opcode, I_ALUOut, I_DestRegIdx  instruction, result/address, destination
//   I_DestValue                       store data
//   I_FetchStall, I_DepStall          upstream stall flags
//   O_LOCK                            valid to Writeback
//   O_Opcode, O_DestRegIdx, O_ALUOut  forwarded instruction fields
//   O_MemOut                          load data
//   O_FetchStall, O_DepStall          registered stall flags
//   O_MemStall                        access in progress
//   O_LEDR, O_LEDG, O_HEX             board output registers
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int DMEM_AW      = 10,
   parameter int DMEM_LATENCY = 0
) (
   input  logic                    I_CLOCK,
   input  logic                    I_RESET,
   input  logic                    I_LOCK,
   input  logic [OPCODE_WIDTH-1:0] I_Opcode,
   input  logic [REG_WIDTH-1:0]    I_ALUOut,
   input  logic [3:0]              I_DestRegIdx,
   input  logic [REG_WIDTH-1:0]    I_DestValue,
   input  logic                    I_FetchStall,
   input  logic                    I_DepStall,
   output logic                    O_LOCK,
   output logic [OPCODE_WIDTH-1:0] O_Opcode,
   output logic [3:0]              O_DestRegIdx,
   output logic [REG_WIDTH-1:0]    O_ALUOut,
   output logic [REG_WIDTH-1:0]    O_MemOut,
   output logic                    O_FetchStall,
   output logic                    O_DepStall,
   output logic                    O_MemStall,
   output logic [9:0]              O_LEDR,
   output logic [7:0]              O_LEDG,
   output logic [15:0]             O_HEX
);

   localparam logic [3:0] LAT = 4'(DMEM_LATENCY);

   mem_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [OPCODE_WIDTH-1:0] op_q;
   logic [REG_WIDTH-1:0]    addr_q;
   logic [REG_WIDTH-1:0]    data_q;
   logic [3:0]              dest_q;

   logic                    capture;
   logic                    complete;
   logic                    pass_thru;
   logic [OPCODE_WIDTH-1:0] acc_op;
   logic [REG_WIDTH-1:0]    acc_addr;
   logic [REG_WIDTH-1:0]    acc_data;
   logic [3:0]              acc_dest;

   logic                    do_load;
   logic                    do_store;
   logic                    mem_we;
   logic                    sw_rd;
   logic                    sw_q;
   logic [REG_WIDTH-1:0]    rdata;

   // The access operands come straight from the inputs for an immediate
   // access and from the capture registers when finishing a delayed one.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      capture  = 1'b0;
      complete = 1'b0;
      acc_op   = I_Opcode;
      acc_addr = I_ALUOut;
      acc_data = I_DestValue;
      acc_dest = I_DestRegIdx;
      case (state_q)
         ST_IDLE: begin
            if (I_LOCK && is_mem_op(I_Opcode)) begin
               if (LAT == 4'd0) begin
                  complete = 1'b1;
               end else begin
                  capture = 1'b1;
                  cnt_d   = LAT;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            acc_op   = op_q;
            acc_addr = addr_q;
            acc_data = data_q;
            acc_dest = dest_q;
            cnt_d    = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
            end
         end
      endcase
   end

   assign pass_thru = (state_q == ST_IDLE) && I_LOCK && !is_mem_op(I_Opcode);
   assign do_load   = complete && (acc_op == OP_LDW);
   assign do_store  = complete && (acc_op == OP_STW);

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         dest_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            op_q   <= I_Opcode;
            addr_q <= I_ALUOut;
            data_q <= I_DestValue;
            dest_q <= I_DestRegIdx;
         end
      end
   end

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         O_LOCK       <= 1'b0;
         O_Opcode     <= '0;
         O_DestRegIdx <= '0;
         O_ALUOut     <= '0;
         O_FetchStall <= 1'b0;
         O_DepStall   <= 1'b0;
         O_MemStall   <= 1'b0;
         sw_q         <= 1'b0;
      end else begin
         O_FetchStall <= I_FetchStall;
         O_DepStall   <= I_DepStall;
         if (capture) begin
            O_LOCK     <= 1'b0;
            O_MemStall <= 1'b1;
         end else if (complete || pass_thru) begin
            O_LOCK       <= 1'b1;
            O_MemStall   <= 1'b0;
            O_Opcode     <= acc_op;
            O_DestRegIdx <= acc_dest;
            O_ALUOut     <= acc_addr;
         end else begin
            O_LOCK <= 1'b0;
         end
         if (do_load) begin
            sw_q <= sw_rd;
         end
      end
   end

`ifdef MEM_IO_EN
   logic       io_ledr;
   logic       io_ledg;
   logic       io_hex;
   logic [9:0] ledr_q;
   logic [7:0] ledg_q;
   logic [15:0] hex_q;

   assign io_ledr = do_store && (acc_addr == ADDR_LEDR);
   assign io_ledg = do_store && (acc_addr == ADDR_LEDG);
   assign io_hex  = do_store && (acc_addr == ADDR_HEX);
   assign mem_we  = do_store && !(io_ledr || io_ledg || io_hex);
   assign sw_rd   = do_load && (acc_addr == ADDR_SW);

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         ledr_q <= '0;
         ledg_q <= '0;
         hex_q  <= '0;
      end else begin
         if (io_ledr) ledr_q <= acc_data[9:0];
         if (io_ledg) ledg_q <= acc_data[7:0];
         if (io_hex)  hex_q  <= acc_data[15:0];
      end
   end

   assign O_LEDR = ledr_q;
   assign O_LEDG = ledg_q;
   assign O_HEX  = hex_q;
`else
   assign mem_we = do_store;
   assign sw_rd  = 1'b0;
   assign O_LEDR = '0;
   assign O_LEDG = '0;
   assign O_HEX  = '0;
`endif

   // Gating with reset keeps an in-flight store from landing in memory.
   memory_stage_data_mem #(
      .AW(DMEM_AW)
   ) u_dmem (
      .clk   (I_CLOCK),
      .rst   (I_RESET),
      .we    (mem_we && !I_RESET),
      .re    (do_load),
      .addr  (acc_addr[DMEM_AW-1:0]),
      .wdata (acc_data),
      .rdata (rdata)
   );

   // The switch bank reads as zero; sw_q remembers whether the last load hit it.
   assign O_MemOut = sw_q ? '0 : rdata;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage at latencies 0, 2 and 3
module tb_memory_stage;
   import memory_stage_pkg::*;

   typedef struct packed {
      logic        lock;
      logic [4:0]  op;
      logic [3:0]  dest;
      logic [15:0] alu;
      logic [15:0] mem;
      logic        stall;
      logic        fs;
      logic        ds;
      logic [9:0]  ledr;
      logic [7:0]  ledg;
      logic [15:0] hex;
   } obs_t;

   typedef struct {
      logic        lock;
      logic [4:0]  op;
      logic [15:0] alu;
      logic [3:0]  dest;
      logic [15:0] dval;
      logic        fs;
      logic        ds;
      obs_t        exp;
   } vec_t;

   typedef struct {
      int   sel;
      obs_t o;
   } sb_t;

   logic        clk;
   logic [2:0]  rst;
   logic        i_lock;
   logic [4:0]  i_op;
   logic [15:0] i_alu;
   logic [3:0]  i_dest;
   logic [15:0] i_dval;
   logic        i_fs;
   logic        i_ds;

   logic        o_lock  [3];
   logic [4:0]  o_op    [3];
   logic [3:0]  o_dest  [3];
   logic [15:0] o_alu   [3];
   logic [15:0] o_mem   [3];
   logic        o_fs    [3];
   logic        o_ds    [3];
   logic        o_stall [3];
   logic [9:0]  o_ledr  [3];
   logic [7:0]  o_ledg  [3];
   logic [15:0] o_hex   [3];

   int   vec_cnt = 0;
   int   miss    = 0;
   sb_t  sbq [$];
   string cur_tag = "init";

   // Instance 0: latency 0, instance 1: latency 2, instance 2: latency 3.
   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         memory_stage #(
            .DMEM_AW      (10),
            .DMEM_LATENCY ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
         ) u_dut (
            .I_CLOCK      (clk),
            .I_RESET      (rst[g]),
            .I_LOCK       (i_lock),
            .I_Opcode     (i_op),
            .I_ALUOut     (i_alu),
            .I_DestRegIdx (i_dest),
            .I_DestValue  (i_dval),
            .I_FetchStall (i_fs),
            .I_DepStall   (i_ds),
            .O_LOCK       (o_lock[g]),
            .O_Opcode     (o_op[g]),
            .O_DestRegIdx (o_dest[g]),
            .O_ALUOut     (o_alu[g]),
            .O_MemOut     (o_mem[g]),
            .O_FetchStall (o_fs[g]),
            .O_DepStall   (o_ds[g]),
            .O_MemStall   (o_stall[g]),
            .O_LEDR       (o_ledr[g]),
            .O_LEDG       (o_ledg[g]),
            .O_HEX        (o_hex[g])
         );
      end
   endgenerate

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic obs_t mk(input logic l, input logic st, input logic [4:0] op,
                               input logic [3:0] d, input logic [15:0] a, input logic [15:0] m,
                               input logic fs = 1'b0, input logic ds = 1'b0,
                               input logic [9:0] lr = 10'h0, input logic [7:0] lg = 8'h0,
                               input logic [15:0] hx = 16'h0);
      obs_t r;
      r.lock = l; r.stall = st; r.op = op; r.dest = d; r.alu = a; r.mem = m;
      r.fs = fs; r.ds = ds; r.ledr = lr; r.ledg = lg; r.hex = hx;
      return r;
   endfunction

   function automatic obs_t actual(input int s);
      obs_t r;
      r.lock = o_lock[s]; r.stall = o_stall[s]; r.op = o_op[s]; r.dest = o_dest[s];
      r.alu = o_alu[s]; r.mem = o_mem[s]; r.fs = o_fs[s]; r.ds = o_ds[s];
      r.ledr = o_ledr[s]; r.ledg = o_ledg[s]; r.hex = o_hex[s];
      return r;
   endfunction

   task automatic cmp(input int s, input obs_t e);
      obs_t a;
      a = actual(s);
      vec_cnt++;
      if (a !== e) begin
         miss++;
         $display("FAIL %s dut%0d #%0d got lock=%b stall=%b op=%h dest=%h alu=%h mem=%h fs=%b ds=%b ledr=%h ledg=%h hex=%h want lock=%b stall=%b op=%h dest=%h alu=%h mem=%h fs=%b ds=%b ledr=%h ledg=%h hex=%h",
                  cur_tag, s, vec_cnt,
                  a.lock, a.stall, a.op, a.dest, a.alu, a.mem, a.fs, a.ds, a.ledr, a.ledg, a.hex,
                  e.lock, e.stall, e.op, e.dest, e.alu, e.mem, e.fs, e.ds, e.ledr, e.ledg, e.hex);
      end
   endtask

   task automatic push(input int s, input obs_t o);
      sb_t x;
      x.sel = s;
      x.o   = o;
      sbq.push_back(x);
   endtask

   // Advance past one falling (active) edge and compare on the next rising edge.
   task automatic tick();
      sb_t x;
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
         x = sbq.pop_front();
         cmp(x.sel, x.o);
      end
   endtask

   task automatic drive(input logic l, input logic [4:0] op, input logic [15:0] a,
                        input logic [3:0] d, input logic [15:0] v);
      i_lock = l; i_op = op; i_alu = a; i_dest = d; i_dval = v; i_fs = 1'b0; i_ds = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v);
      i_lock = v.lock; i_op = v.op; i_alu = v.alu; i_dest = v.dest; i_dval = v.dval;
      i_fs = v.fs; i_ds = v.ds;
      push(0, v.exp);
      tick();
   endtask

   vec_t tbl [13];
`ifdef MEM_IO_EN
   vec_t io_tbl [6];
`else
   vec_t io_tbl [4];
`endif

   initial begin
      tbl[0]  = '{1'b1, OP_STW, 16'h0005, 4'd0, 16'h1234, 1'b1, 1'b0, mk(1, 0, OP_STW, 0, 16'h0005, 16'h0000, 1, 0)};
      tbl[1]  = '{1'b1, OP_LDW, 16'h0005, 4'd3, 16'h0000, 1'b0, 1'b1, mk(1, 0, OP_LDW, 3, 16'h0005, 16'h1234, 0, 1)};
      tbl[2]  = '{1'b1, OP_ADD, 16'h00FF, 4'd7, 16'h0000, 1'b1, 1'b1, mk(1, 0, OP_ADD, 7, 16'h00FF, 16'h1234, 1, 1)};
      tbl[3]  = '{1'b0, OP_LDW, 16'h0005, 4'd9, 16'h9999, 1'b0, 1'b0, mk(0, 0, OP_ADD, 7, 16'h00FF, 16'h1234)};
      tbl[4]  = '{1'b1, OP_STW, 16'h0405, 4'd1, 16'hABCD, 1'b0, 1'b0, mk(1, 0, OP_STW, 1, 16'h0405, 16'h1234)};
      tbl[5]  = '{1'b1, OP_LDW, 16'h0005, 4'd2, 16'h0000, 1'b0, 1'b0, mk(1, 0, OP_LDW, 2, 16'h0005, 16'hABCD)};
      tbl[6]  = '{1'b1, OP_STW, 16'h0010, 4'd0, 16'h5555, 1'b0, 1'b0, mk(1, 0, OP_STW, 0, 16'h0010, 16'hABCD)};
      tbl[7]  = '{1'b1, OP_STW, 16'h0011, 4'd0, 16'hAAAA, 1'b0, 1'b0, mk(1, 0, OP_STW, 0, 16'h0011, 16'hABCD)};
      tbl[8]  = '{1'b1, OP_LDW, 16'h0010, 4'd4, 16'h0000, 1'b0, 1'b0, mk(1, 0, OP_LDW, 4, 16'h0010, 16'h5555)};
      tbl[9]  = '{1'b1, OP_LDW, 16'h0011, 4'd5, 16'h0000, 1'b0, 1'b0, mk(1, 0, OP_LDW, 5, 16'h0011, 16'hAAAA)};
      tbl[10] = '{1'b0, OP_STW, 16'h0011, 4'd6, 16'h0000, 1'b0, 1'b0, mk(0, 0, OP_LDW, 5, 16'h0011, 16'hAAAA)};
      tbl[11] = '{1'b1, OP_LDW, 16'h0011, 4'd8, 16'h0000, 1'b0, 1'b0, mk(1, 0, OP_LDW, 8, 16'h0011, 16'hAAAA)};
      tbl[12] = '{1'b1, OP_ADD, 16'h1357, 4'd2, 16'h0000, 1'b0, 1'b0, mk(1, 0, OP_ADD, 2, 16'h1357, 16'hAAAA)};
`ifdef MEM_IO_EN
      io_tbl[0] = '{1'b1, OP_STW, 16'h03F2, 4'd0, 16'h7777, 1'b0, 1'b0, mk(1, 0, OP_STW, 0, 16'h03F2, 16'hAAAA)};
      io_tbl[1] = '{1'b1, OP_STW, ADDR_LEDR, 4'd0, 16'h03FF, 1'b0, 1'b0, mk(1, 0, OP_STW, 0, ADDR_LEDR, 16'hAAAA, 0, 0, 10'h3FF)};
      io_tbl[2] = '{1'b1, OP_STW, ADDR_HEX, 4'd0, 16'hBEEF, 1'b0, 1'b0, mk(1, 0, OP_STW, 0, ADDR_HEX, 16'hAAAA, 0, 0, 10'h3FF, 8'h00, 16'hBEEF)};
      io_tbl[3] = '{1'b1, OP_STW, ADDR_LEDG, 4'd0, 16'h12A5, 1'b0, 1'b0, mk(1, 0, OP_STW, 0, ADDR_LEDG, 16'hAAAA, 0, 0, 10'h3FF, 8'hA5, 16'hBEEF)};
      io_tbl[4] = '{1'b1, OP_LDW, 16'h03F2, 4'd1, 16'h0000, 1'b0, 1'b0, mk(1, 0, OP_LDW, 1, 16'h03F2, 16'h7777, 0, 0, 10'h3FF, 8'hA5, 16'hBEEF)};
      io_tbl[5] = '{1'b1, OP_LDW, ADDR_SW, 4'd2, 16'h0000, 1'b0, 1'b0, mk(1, 0, OP_LDW, 2, ADDR_SW, 16'h0000, 0, 0, 10'h3FF, 8'hA5, 16'hBEEF)};
`else
      io_tbl[0] = '{1'b1, OP_STW, ADDR_LEDR, 4'd0, 16'h03FF, 1'b0, 1'b0, mk(1, 0, OP_STW, 0, ADDR_LEDR, 16'hAAAA)};
      io_tbl[1] = '{1'b1, OP_LDW, 16'h03F0, 4'd1, 16'h0000, 1'b0, 1'b0, mk(1, 0, OP_LDW, 1, 16'h03F0, 16'h03FF)};
      io_tbl[2] = '{1'b1, OP_STW, ADDR_HEX, 4'd0, 16'hBEEF, 1'b0, 1'b0, mk(1, 0, OP_STW, 0, ADDR_HEX, 16'h03FF)};
      io_tbl[3] = '{1'b1, OP_LDW, 16'h03F2, 4'd2, 16'h0000, 1'b0, 1'b0, mk(1, 0, OP_LDW, 2, 16'h03F2, 16'hBEEF)};
`endif

      rst = 3'b111;
      drive(1'b0, OP_ADD, 16'h0, 4'd0, 16'h0);
      tick();
      tick();

      cur_tag = "reset_state";
      cmp(0, mk(0, 0, 5'h0, 0, 16'h0, 16'h0));
      cmp(1, mk(0, 0, 5'h0, 0, 16'h0, 16'h0));
      rst[0] = 1'b0;

      cur_tag = "table_lat0";
      for (int i = 0; i < 13; i++) begin
         apply_vec(tbl[i]);
      end

      cur_tag = "board_io";
`ifdef MEM_IO_EN
      for (int i = 0; i < 6; i++) begin
         apply_vec(io_tbl[i]);
      end
`else
      for (int i = 0; i < 4; i++) begin
         apply_vec(io_tbl[i]);
      end
`endif

      // Latency 2: stall for exactly two edges, inputs ignored while waiting.
      cur_tag = "wait_lat2";
      drive(1'b0, OP_ADD, 16'h0, 4'd0, 16'h0);
      rst[1] = 1'b0;
      push(1, mk(0, 0, 5'h0, 0, 16'h0, 16'h0));
      tick();
      drive(1'b1, OP_STW, 16'h0014, 4'd0, 16'h4242);
      push(1, mk(0, 1, 5'h0, 0, 16'h0, 16'h0));
      tick();
      drive(1'b0, OP_ADD, 16'h0, 4'd0, 16'h0);
      push(1, mk(0, 1, 5'h0, 0, 16'h0, 16'h0));
      tick();
      push(1, mk(1, 0, OP_STW, 0, 16'h0014, 16'h0));
      tick();
      drive(1'b1, OP_LDW, 16'h0014, 4'd6, 16'h0);
      push(1, mk(0, 1, OP_STW, 0, 16'h0014, 16'h0));
      tick();
      drive(1'b1, OP_ADD, 16'hFFFF, 4'd15, 16'h0);
      push(1, mk(0, 1, OP_STW, 0, 16'h0014, 16'h0));
      tick();
      push(1, mk(1, 0, OP_LDW, 6, 16'h0014, 16'h4242));
      tick();
      drive(1'b0, OP_ADD, 16'h0, 4'd0, 16'h0);
      push(1, mk(0, 0, OP_LDW, 6, 16'h0014, 16'h4242));
      tick();

      // Latency 3: reset during the second wait cycle discards the store.
      cur_tag = "reset_mid_wait";
      rst[2] = 1'b0;
      drive(1'b1, OP_STW, 16'h0009, 4'd0, 16'h1111);
      push(2, mk(0, 1, 5'h0, 0, 16'h0, 16'h0));
      tick();
      drive(1'b0, OP_ADD, 16'h0, 4'd0, 16'h0);
      push(2, mk(0, 1, 5'h0, 0, 16'h0, 16'h0));
      tick();
      push(2, mk(0, 1, 5'h0, 0, 16'h0, 16'h0));
      tick();
      push(2, mk(1, 0, OP_STW, 0, 16'h0009, 16'h0));
      tick();
      drive(1'b1, OP_STW, 16'h0009, 4'd0, 16'hDEAD);
      push(2, mk(0, 1, OP_STW, 0, 16'h0009, 16'h0));
      tick();
      drive(1'b0, OP_ADD, 16'h0, 4'd0, 16'h0);
      push(2, mk(0, 1, OP_STW, 0, 16'h0009, 16'h0));
      tick();
      rst[2] = 1'b1;
      #1;
      cmp(2, mk(0, 0, 5'h0, 0, 16'h0, 16'h0));
      tick();
      rst[2] = 1'b0;
      push(2, mk(0, 0, 5'h0, 0, 16'h0, 16'h0));
      tick();
      drive(1'b1, OP_LDW, 16'h0009, 4'd1, 16'h0);
      push(2, mk(0, 1, 5'h0, 0, 16'h0, 16'h0));
      tick();
      drive(1'b0, OP_ADD, 16'h0, 4'd0, 16'h0);
      push(2, mk(0, 1, 5'h0, 0, 16'h0, 16'h0));
      tick();
      push(2, mk(0, 1, 5'h0, 0, 16'h0, 16'h0));
      tick();
      push(2, mk(1, 0, OP_LDW, 1, 16'h0009, 16'h1111));
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the 5-stage pipeline. It consumes the Execute stage output bundle, performs data-memory loads and stores, and optionally drives memory-mapped board I/O. It forwards results and stall flags to Writeback. A parameterised access latency is modelled with a wait FSM that back-pressures upstream stages.

## Interface
Parameters:
- DMEM_AW, 10: data-memory word-address width; depth is 2^DMEM_AW words of `REG_WIDTH.
- DMEM_LATENCY, 0: extra wait cycles per LDW/STW, 0..15.

Ports:
- I_CLOCK  in  1  stage clock; all state updates on the negedge.
- I_RESET  in  1  asynchronous, active-high reset.
- I_LOCK  in  1  upstream valid.
- I_Opcode  in  `OPCODE_WIDTH  opcode from Execute.
- I_ALUOut  in  `REG_WIDTH  result, or effective address for LDW/STW.
- I_DestRegIdx  in  4  destination register.
- I_DestValue  in  `REG_WIDTH  store data for STW.
- I_FetchStall, I_DepStall  in  1 each  upstream stall flags.
- O_LOCK  out  1  valid to Writeback.
- O_Opcode  out  `OPCODE_WIDTH  forwarded opcode.
- O_DestRegIdx  out  4  forwarded destination register.
- O_ALUOut  out  `REG_WIDTH  forwarded ALU result.
- O_MemOut  out  `REG_WIDTH  load data.
- O_FetchStall, O_DepStall  out  1 each  forwarded stall flags.
- O_MemStall  out  1  busy; Fetch, Decode and Execute hold their state while this is 1.
- O_LEDR  out  10  LED register.
- O_LEDG  out  8  LED register.
- O_HEX  out  16  display register.

## Operation
- FSM states are IDLE and WAIT. A 4-bit counter holds the remaining wait cycles.
- IDLE, I_LOCK=1, opcode not LDW/STW: register the inputs to the outputs and set O_LOCK=1. O_MemOut holds its value.
- IDLE, I_LOCK=1, LDW/STW, DMEM_LATENCY=0: the access completes on the same edge.
- IDLE, I_LOCK=1, LDW/STW, DMEM_LATENCY>0:
  - Capture opcode, address, data and destination index.
  - Load the counter with DMEM_LATENCY and go to WAIT.
  - Drive O_MemStall=1 and O_LOCK=0.
- WAIT: decrement the counter each edge. Inputs are ignored.
- WAIT, counter reaches 1: on that edge, perform the captured access, output the result with O_LOCK=1, clear O_MemStall and return to IDLE.
- Access completion:
  - STW writes I_DestValue to dmem[addr[DMEM_AW-1:0]]. Upper address bits are ignored.
  - LDW returns dmem[addr] as it was before this edge. A store followed by a load to the same address returns the new value.
- I_LOCK=0 in IDLE: set O_LOCK=0; all other outputs hold.
- O_FetchStall and O_DepStall are registered copies of the inputs every edge, including in WAIT.
- Reset, applied at any time including mid-WAIT:
  - All outputs go to 0. The FSM returns to IDLE and the counter to 0.
  - A pending store is discarded.
  - Memory contents are not reset.

## Timing
- Latency from input to output is 1 + DMEM_LATENCY negedges for LDW/STW, and 1 negedge otherwise.
- O_MemStall rises on the accept edge and falls on the completion edge.
- Throughput is one instruction per edge when DMEM_LATENCY=0.

## Configuration
- MEM_IO_EN defined:
  - STW to `ADDR_LEDR, `ADDR_LEDG or `ADDR_HEX updates the matching register instead of dmem. The register is truncated to its port width.
  - LDW from `ADDR_SW returns 0.
- MEM_IO_EN undefined: those addresses are ordinary dmem locations, and O_LEDR, O_LEDG and O_HEX are tied to 0.

## Structure
- global_def.h holds `REG_WIDTH, `OPCODE_WIDTH, `OP_LDW, `OP_STW, `ADDR_LEDR, `ADDR_LEDG, `ADDR_HEX and `ADDR_SW.
- One sub-module, data_mem: a synchronous single-port RAM with a negedge write and a read-before-write read.

## Test plan
- Reset mid-WAIT: DMEM_LATENCY=3, STW issued, I_RESET pulsed on the second wait cycle → outputs are 0, FSM is IDLE, and a later LDW from that address does not return the stored value.
- Store/load: DMEM_LATENCY=0. STW of 16'h1234 to address 5, then LDW r3 from address 5 → O_MemOut=16'h1234, O_DestRegIdx=3, O_LOCK=1 one edge after each accept.
- Wait FSM: DMEM_LATENCY=2, LDW issued →
  - O_MemStall is high for exactly 2 edges.
  - O_LOCK is 0 on the first edge and 1 on the third.
  - Input changes during WAIT are ignored.
- Pass-through: ADD with I_ALUOut=16'h00FF and I_LOCK=1 → O_ALUOut=16'h00FF and O_MemOut unchanged. With I_LOCK=0 → O_LOCK=0 and the other outputs hold.
- MEM_IO_EN defined:
  - STW 16'h03FF to `ADDR_LEDR → O_LEDR=10'h3FF.
  - STW 16'hBEEF to `ADDR_HEX → O_HEX=16'hBEEF, and dmem is unchanged.
- Address wrap: DMEM_AW=10. STW to address 16'h0405, then LDW from 16'h0005 → returns the stored value.
